serpent_inv_lt_pipe: RTL and testbench
======================================

Name: serpent_inv_lt_pipe

Overview:
- Decryption-path counterpart of the Serpent linear transform: applies the Serpent inverse linear transform (InvLT) to a 128-bit state.
- Two-stage pipeline with valid/ready flow control on both sides, sitting between the round-key XOR and the inverse S-box stage of the decrypt datapath.
- A per-beat bypass flag passes data unchanged, for the decrypt round that has no InvLT.
- A sideband tag (round index) travels with each beat so downstream key selection stays aligned.

Parameters:
- TAG_W, 6, width of the sideband tag carried alongside each beat (round index).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_data  input  128  state; X0=[127:96], X1=[95:64], X2=[63:32], X3=[31:0].
- i_bypass  input  1  1 = pass i_data unchanged; 0 = apply InvLT.
- i_tag  input  TAG_W  sideband tag, returned unchanged with the beat.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the beat.
- o_data  output  128  transformed (or bypassed) state, same word packing as i_data.
- o_tag  output  TAG_W  tag of the output beat.

Behaviour:
- Transfer rules: an input transfer occurs when i_valid && o_ready; an output transfer occurs when o_valid && i_ready.
- InvLT math, all 32-bit with rotates modulo 32 and shifts zero-filling:
  - Stage 1:
    - X2=ROR22(X2); X0=ROR5(X0);
    - X2=X2^X3^(X1<<7); X0=X0^X1^X3;
    - X3=ROR7(X3); X1=ROR1(X1).
  - Stage 2:
    - X3=X3^X2^(X0<<3); X1=X1^X0^X2;
    - X2=ROR3(X2); X0=ROR13(X0).
- Bypass beats are not transformed in either stage; the data, bypass flag and tag are carried through the stage registers unchanged.
- Pipeline registers:
  - s1: valid, data, bypass, tag.
  - s2: valid, data, tag. s2 drives o_data, o_tag and o_valid directly.
  - No combinational path from i_data to o_data.
- Flow control:
  - s2_en = !s2_valid || i_ready.
  - s1_en = !s1_valid || s2_en.
  - o_ready = s1_en. This is combinational from i_ready; there is no skid buffer.
- When s2_en: s2_valid <= s1_valid, and the s2 payload loads from s1 (processed or bypassed).
- When s1_en: s1_valid <= i_valid && o_ready, and the s1 payload loads from the input.
- Payload registers may load only when their stage's valid is set (power choice); when a valid is low, its payload is don't-care.
- Latency: 2 cycles from input transfer to o_valid with no backpressure. Throughput is 1 beat/cycle.
- Stall: while o_valid && !i_ready, o_data and o_tag hold stable and o_valid stays high.
  - A bubble in s1 may still fill during the stall.
  - Once both stages are full, o_ready=0.
- Simultaneous input and output transfer with both stages full: the pipeline advances as a shift, with no beat lost or duplicated.
- Ordering: strictly in-order. Beat count out equals beat count in.
- Reset (synchronous, i_rst=1):
  - s1_valid=0, s2_valid=0, so o_valid=0.
  - o_data=0 and o_tag=0 (payload registers cleared).
  - o_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats.
  - While i_rst=1, o_ready is don't-care and no input is captured.

Decomposition:
- Shared package serpent_pkg:
  - Rotation constants (13, 3, 1, 7, 5, 22) and shift constants (3, 7).
  - STATE_W=128 and WORD_W=32.
  - The forward LT and InvLT functions, so the bench and the encrypt path share one definition.
- Sub-module serpent_inv_lt_half: combinational, with a stage-select input; instantiated twice for stage 1 and stage 2.

Test Plan:
- Single beat, i_data=0x00000000_00000000_00000000_00000001, i_bypass=0, i_ready=1 -> o_valid exactly 2 cycles later, o_data=0x00080000_00000000_20000000_02000009.
- Same data with i_bypass=1, i_tag=6'd31 -> o_data=0x00000000_00000000_00000000_00000001, o_tag=6'd31, after 2 cycles.
- 1000 random beats, i_bypass=0, continuous valid/ready -> o_data == InvLT(i_data); forward LT(o_data) == i_data; 1 beat/cycle; tags in order.
- Random i_valid and i_ready toggling (50%) -> no loss or duplication; o_data and o_tag stable while o_valid && !i_ready; o_ready=0 only when both stages are full.
- i_ready=0 for 5 cycles with 3 beats offered -> exactly 2 accepted; after release, 3 beats emerge in order.
- i_rst pulse with 2 beats in flight -> next cycle o_valid=0 and o_data=0; those beats never appear at the output.

Source files
------------

// File: rtl/serpent_pkg.sv
// Serpent linear-transform constants, state packing and the forward/inverse LT functions
// shared by the encrypt datapath, the decrypt datapath and verification.
package serpent_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;

    localparam int ROT_A = 13;
    localparam int ROT_B = 3;
    localparam int ROT_C = 1;
    localparam int ROT_D = 7;
    localparam int ROT_E = 5;
    localparam int ROT_F = 22;
    localparam int SHL_B = 3;
    localparam int SHL_D = 7;

    typedef logic [WORD_W-1:0] word_t;

    // x0 occupies the most significant word of the 128-bit state
    typedef struct packed {
        word_t x0;
        word_t x1;
        word_t x2;
        word_t x3;
    } state_t;

    function automatic word_t rol(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic state_t lt_fwd(input state_t s);
        state_t r;
        r    = s;
        r.x0 = rol(r.x0, ROT_A);
        r.x2 = rol(r.x2, ROT_B);
        r.x1 = r.x1 ^ r.x0 ^ r.x2;
        r.x3 = r.x3 ^ r.x2 ^ (r.x0 << SHL_B);
        r.x1 = rol(r.x1, ROT_C);
        r.x3 = rol(r.x3, ROT_D);
        r.x0 = r.x0 ^ r.x1 ^ r.x3;
        r.x2 = r.x2 ^ r.x3 ^ (r.x1 << SHL_D);
        r.x0 = rol(r.x0, ROT_E);
        r.x2 = rol(r.x2, ROT_F);
        return r;
    endfunction

    function automatic state_t inv_lt_s1(input state_t s);
        state_t r;
        r    = s;
        r.x2 = ror(r.x2, ROT_F);
        r.x0 = ror(r.x0, ROT_E);
        r.x2 = r.x2 ^ r.x3 ^ (r.x1 << SHL_D);
        r.x0 = r.x0 ^ r.x1 ^ r.x3;
        r.x3 = ror(r.x3, ROT_D);
        r.x1 = ror(r.x1, ROT_C);
        return r;
    endfunction

    function automatic state_t inv_lt_s2(input state_t s);
        state_t r;
        r    = s;
        r.x3 = r.x3 ^ r.x2 ^ (r.x0 << SHL_B);
        r.x1 = r.x1 ^ r.x0 ^ r.x2;
        r.x2 = ror(r.x2, ROT_B);
        r.x0 = ror(r.x0, ROT_A);
        return r;
    endfunction

    function automatic state_t inv_lt(input state_t s);
        return inv_lt_s2(inv_lt_s1(s));
    endfunction

endpackage

// File: rtl/serpent_inv_lt_half.sv
// One half of the Serpent inverse linear transform, selected by i_stage (0 = first, 1 = second).
// Purely combinational; bypass beats pass through untouched.
module serpent_inv_lt_half
    import serpent_pkg::*;
(
    input  logic               i_stage,
    input  logic [STATE_W-1:0] i_data,
    input  logic               i_bypass,
    output logic [STATE_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (!i_bypass) begin
            if (i_stage) begin
                o_data = inv_lt_s2(state_t'(i_data));
            end else begin
                o_data = inv_lt_s1(state_t'(i_data));
            end
        end
    end

endmodule

// File: rtl/serpent_inv_lt_pipe.sv
// Serpent inverse linear transform for the decrypt path, with per-beat bypass and a round-index tag.
// Latency 2 cycles, 1 beat/cycle; first InvLT half feeds s1, second half feeds s2 (which drives the outputs).
// Backpressure: o_ready is combinational from i_ready (no skid buffer); low only when both stages are full.
module serpent_inv_lt_pipe
    import serpent_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [STATE_W-1:0] i_data,
    input  logic               i_bypass,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [STATE_W-1:0] o_data,
    output logic [TAG_W-1:0]   o_tag
);

    logic               r_s1_vld;
    logic [STATE_W-1:0] r_s1_dat;
    logic               r_s1_byp;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_vld;
    logic [STATE_W-1:0] r_s2_dat;
    logic [TAG_W-1:0]   r_s2_tag;

    logic               w_s1_en;
    logic               w_s2_en;
    logic [STATE_W-1:0] w_s1_nxt;
    logic [STATE_W-1:0] w_s2_nxt;

    assign w_s2_en = !r_s2_vld || i_ready;
    assign w_s1_en = !r_s1_vld || w_s2_en;
    assign o_ready = w_s1_en;

    assign o_valid = r_s2_vld;
    assign o_data  = r_s2_dat;
    assign o_tag   = r_s2_tag;

    serpent_inv_lt_half u_half_s1 (
        .i_stage  (1'b0),
        .i_data   (i_data),
        .i_bypass (i_bypass),
        .o_data   (w_s1_nxt)
    );

    serpent_inv_lt_half u_half_s2 (
        .i_stage  (1'b1),
        .i_data   (r_s1_dat),
        .i_bypass (r_s1_byp),
        .o_data   (w_s2_nxt)
    );

    // Payloads only load alongside a valid beat, so idle stages do not toggle the wide registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_byp <= 1'b0;
            r_s1_tag <= '0;
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_tag <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_vld <= i_valid;
                if (i_valid) begin
                    r_s1_dat <= w_s1_nxt;
                    r_s1_byp <= i_bypass;
                    r_s1_tag <= i_tag;
                end
            end
            if (w_s2_en) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_dat <= w_s2_nxt;
                    r_s2_tag <= r_s1_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_serpent_inv_lt_pipe.sv
// Bench for serpent_inv_lt_pipe: directed steps plus a scoreboard fed on input transfers
// and drained on output transfers.
module tb_serpent_inv_lt_pipe;
    import serpent_pkg::*;

    localparam int TAG_W = 6;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic               o_ready;
    logic [STATE_W-1:0] i_data;
    logic               i_bypass;
    logic [TAG_W-1:0]   i_tag;
    logic               o_valid;
    logic               i_ready;
    logic [STATE_W-1:0] o_data;
    logic [TAG_W-1:0]   o_tag;

    always #5 i_clk = ~i_clk;

    serpent_inv_lt_pipe #(.TAG_W(TAG_W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_bypass (i_bypass),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_tag    (o_tag)
    );

    typedef struct {
        logic [STATE_W-1:0] exp_dat;
        logic [STATE_W-1:0] in_dat;
        logic               byp;
        logic [TAG_W-1:0]   tag;
    } sb_t;

    sb_t sb_q[$];

    int checks  = 0;
    int errors  = 0;
    int out_cnt = 0;

    logic               prev_stall = 1'b0;
    logic [STATE_W-1:0] prev_dat   = '0;
    logic [TAG_W-1:0]   prev_tag   = '0;

    task automatic check(input string name, input logic [STATE_W-1:0] got, input logic [STATE_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [STATE_W-1:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: inputs change just after posedge, so values at negedge decide the next edge's transfers
    always @(negedge i_clk) begin
        sb_t e;
        if (i_rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 128'(o_valid), 128'(1));
                check("stall_dat", o_data, prev_dat);
                check("stall_tag", 128'(o_tag), 128'(prev_tag));
            end
            check("o_ready", 128'(o_ready), 128'((sb_q.size() < 2) || i_ready));
            if (o_valid && i_ready) begin
                check("out_has_exp", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("out_dat", o_data, e.exp_dat);
                    check("out_tag", 128'(o_tag), 128'(e.tag));
                    if (!e.byp) check("fwd_lt", lt_fwd(state_t'(o_data)), e.in_dat);
                end
                out_cnt++;
            end
            if (i_valid && o_ready) begin
                e.in_dat  = i_data;
                e.byp     = i_bypass;
                e.tag     = i_tag;
                e.exp_dat = i_bypass ? i_data : inv_lt(state_t'(i_data));
                sb_q.push_back(e);
            end
            prev_stall = o_valid && !i_ready;
            prev_dat   = o_data;
            prev_tag   = o_tag;
        end
    end

    initial begin
        logic               acc;
        int                 base;
        int                 accepted;
        int                 k;
        int                 waited;
        logic [STATE_W-1:0] one;

        one      = 128'h1;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_bypass = 1'b0;
        i_tag    = '0;
        i_ready  = 1'b1;
        repeat (3) cyc();
        @(negedge i_clk);
        check("rst_vld", 128'(o_valid), 128'(0));
        check("rst_dat", o_data, 128'h0);
        check("rst_tag", 128'(o_tag), 128'(0));
        cyc();
        i_rst = 1'b0;

        // Single InvLT beat: o_valid exactly 2 cycles after it is offered
        i_valid = 1'b1; i_data = one; i_bypass = 1'b0; i_tag = 6'd5;
        cyc();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("lat_c1_vld", 128'(o_valid), 128'(0));
        cyc();
        @(negedge i_clk);
        check("lat_c2_vld", 128'(o_valid), 128'(1));
        check("vec_dat", o_data, 128'h00080000_00000000_20000000_02000009);
        check("vec_tag", 128'(o_tag), 128'(5));
        cyc();

        // Bypass beat
        i_valid = 1'b1; i_data = one; i_bypass = 1'b1; i_tag = 6'd31;
        cyc();
        i_valid = 1'b0;
        cyc();
        @(negedge i_clk);
        check("byp_vld", 128'(o_valid), 128'(1));
        check("byp_dat", o_data, one);
        check("byp_tag", 128'(o_tag), 128'(31));
        cyc();
        i_bypass = 1'b0;

        // Continuous 1000-beat burst
        base = out_cnt;
        for (int i = 0; i < 1000; i++) begin
            i_valid = 1'b1;
            i_data  = rand_state();
            i_tag   = i[TAG_W-1:0];
            @(negedge i_clk);
            if (!o_ready) check("burst_rdy", 128'(o_ready), 128'(1));
            cyc();
        end
        i_valid = 1'b0;
        repeat (2) cyc();
        check("burst_cnt", 128'(out_cnt - base), 128'(1000));

        // Random valid/ready toggling; a beat is held until accepted
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!i_valid || acc) begin
                i_valid  = 1'($urandom_range(0, 1));
                i_data   = rand_state();
                i_tag    = TAG_W'($urandom());
                i_bypass = ($urandom_range(0, 3) == 0);
            end
            i_ready = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            acc = i_valid && o_ready;
            cyc();
        end
        i_valid = 1'b0; i_bypass = 1'b0; i_ready = 1'b1;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin cyc(); waited++; end
        check("rand_drain", 128'(sb_q.size()), 128'(0));

        // Downstream stalled for 5 cycles with 3 beats offered
        base = out_cnt; accepted = 0; k = 0;
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_data  = {96'h0, 32'hA000_0000 + 32'(k)};
            i_tag   = TAG_W'(40 + k);
            @(negedge i_clk);
            acc = o_ready;
            cyc();
            if (acc) begin accepted++; k++; end
        end
        check("stall_acc", 128'(accepted), 128'(2));
        i_ready = 1'b1;
        waited = 0;
        while (k < 3 && waited < 10) begin
            i_valid = 1'b1;
            i_data  = {96'h0, 32'hA000_0000 + 32'(k)};
            i_tag   = TAG_W'(40 + k);
            @(negedge i_clk);
            acc = o_ready;
            cyc();
            if (acc) k++;
            waited++;
        end
        i_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin cyc(); waited++; end
        check("stall_out_cnt", 128'(out_cnt - base), 128'(3));

        // Reset with two beats in flight
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = rand_state(); i_tag = 6'd11;
        cyc();
        i_data = rand_state(); i_tag = 6'd12;
        cyc();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("pre_rst_vld", 128'(o_valid), 128'(1));
        cyc();
        i_rst = 1'b1;
        cyc();
        @(negedge i_clk);
        check("midrst_vld", 128'(o_valid), 128'(0));
        check("midrst_dat", o_data, 128'h0);
        cyc();
        i_rst = 1'b0; i_ready = 1'b1;
        base = out_cnt;
        repeat (5) cyc();
        check("midrst_no_out", 128'(out_cnt - base), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
